// File: rtl/mem_arbiter_2port_if.sv
// Memory-side bus of the two-port arbiter: one request strobe out, one acknowledge back.
interface mem_arbiter_2port_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                  mem_valid;
    logic                  mem_wr_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wdata;
    logic [WIDTH-1:0]      mem_rdata;
    logic                  mem_ready;

    modport master (
        output mem_valid,
        output mem_wr_rd,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_valid,
        input  mem_wr_rd,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mem_arbiter_2port.sv
// Round-robin arbiter sharing one single-outstanding memory port between two requesters,
// with a WAIT-cycle timeout that completes the transaction with an error flag.
module mem_arbiter_2port #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  valid0_i,
    input  logic                  wr_rd0_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [WIDTH-1:0]      wdata0_i,
    output logic                  ready0_o,
    output logic [WIDTH-1:0]      rdata0_o,

    input  logic                  valid1_i,
    input  logic                  wr_rd1_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [WIDTH-1:0]      wdata1_i,
    output logic                  ready1_o,
    output logic [WIDTH-1:0]      rdata1_o,

    output logic                  err_o,
    mem_arbiter_2port_if.master   mem,
    output logic                  busy_o,
    output logic                  grant_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic                  last_served;
    logic                  win;

    logic                  mem_valid_q;
    logic                  mem_wr_rd_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0]      mem_wdata_q;

    assign mem.mem_valid = mem_valid_q;
    assign mem.mem_wr_rd = mem_wr_rd_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

    // On a tie the requester not served last wins; last_served resets to 1 so port 0 wins first.
    always_comb begin
        win = 1'b0;
        if (valid0_i && valid1_i) begin
            win = ~last_served;
        end else if (valid1_i) begin
            win = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            last_served <= 1'b1;
            mem_valid_q <= 1'b0;
            mem_wr_rd_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ready0_o    <= 1'b0;
            ready1_o    <= 1'b0;
            rdata0_o    <= '0;
            rdata1_o    <= '0;
            err_o       <= 1'b0;
            busy_o      <= 1'b0;
            grant_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid0_i || valid1_i) begin
                        grant_o     <= win;
                        mem_wr_rd_q <= win ? wr_rd1_i : wr_rd0_i;
                        mem_addr_q  <= win ? addr1_i  : addr0_i;
                        mem_wdata_q <= win ? wdata1_i : wdata0_i;
                        mem_valid_q <= 1'b1;
                        busy_o      <= 1'b1;
                        state       <= ISSUE;
                    end
                end

                ISSUE: begin
                    mem_valid_q <= 1'b0;
                    cnt         <= '0;
                    state       <= WAIT;
                end

                // An acknowledge in the final WAIT cycle still counts as success.
                WAIT: begin
                    if (mem.mem_ready) begin
                        if (!mem_wr_rd_q) begin
                            if (grant_o) begin
                                rdata1_o <= mem.mem_rdata;
                            end else begin
                                rdata0_o <= mem.mem_rdata;
                            end
                        end
                        err_o    <= 1'b0;
                        ready0_o <= ~grant_o;
                        ready1_o <= grant_o;
                        state    <= DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        err_o    <= 1'b1;
                        ready0_o <= ~grant_o;
                        ready1_o <= grant_o;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    ready0_o    <= 1'b0;
                    ready1_o    <= 1'b0;
                    err_o       <= 1'b0;
                    last_served <= grant_o;
                    cnt         <= '0;
                    busy_o      <= 1'b0;
                    state       <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    a_ready_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
        !(ready0_o && ready1_o));

    a_issue_single_cycle: assert property (@(posedge clk_i) disable iff (rst_i)
        mem_valid_q |=> !mem_valid_q);

endmodule

// File: tb/tb_mem_arbiter_2port.sv
// Directed bench for mem_arbiter_2port with a one-cycle-latency memory model behind the bus.
module tb_mem_arbiter_2port;

    localparam int W  = 16;
    localparam int AW = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          valid0, valid1, wr_rd0, wr_rd1;
    logic [AW-1:0] addr0, addr1;
    logic [W-1:0]  wdata0, wdata1;
    logic          ready0, ready1, err, busy, grant;
    logic [W-1:0]  rdata0, rdata1;

    mem_arbiter_2port_if #(.WIDTH(W), .ADDR_WIDTH(AW)) mbus ();

    mem_arbiter_2port #(.WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .valid0_i (valid0),
        .wr_rd0_i (wr_rd0),
        .addr0_i  (addr0),
        .wdata0_i (wdata0),
        .ready0_o (ready0),
        .rdata0_o (rdata0),
        .valid1_i (valid1),
        .wr_rd1_i (wr_rd1),
        .addr1_i  (addr1),
        .wdata1_i (wdata1),
        .ready1_o (ready1),
        .rdata1_o (rdata1),
        .err_o    (err),
        .mem      (mbus.master),
        .busy_o   (busy),
        .grant_o  (grant)
    );

    // Memory model: acknowledges one cycle after the strobe unless mem_en is low.
    logic [W-1:0]  mem [16];
    logic          mem_en;
    logic          stray;
    logic          mrdy = 1'b0;
    logic [W-1:0]  mrd = '0;
    int            mv_count = 0;
    logic [AW-1:0] last_wa = '0;
    logic [W-1:0]  last_wd = '0;

    assign mbus.mem_ready = mrdy | stray;
    assign mbus.mem_rdata = mrd;

    always @(posedge clk) begin
        mrdy <= 1'b0;
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[3] <= 16'hBEEF;
            mrd    <= '0;
        end else if (mbus.mem_valid) begin
            mv_count <= mv_count + 1;
            if (mem_en) begin
                mrdy <= 1'b1;
                if (mbus.mem_wr_rd) begin
                    mem[mbus.mem_addr] <= mbus.mem_wdata;
                    last_wa            <= mbus.mem_addr;
                    last_wd            <= mbus.mem_wdata;
                end else begin
                    mrd <= mem[mbus.mem_addr];
                end
            end
        end
    end

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rdy(input int port, input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(port == 1 ? ready1 : ready0) && n < maxc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int mvc;
        int pulses;
        int overlap;

        rst = 1'b1; stray = 1'b0; mem_en = 1'b1;
        valid0 = 1'b0; wr_rd0 = 1'b0; addr0 = '0; wdata0 = '0;
        valid1 = 1'b0; wr_rd1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready0", ready0, 0);
        chk("rst_ready1", ready1, 0);
        chk("rst_err", err, 0);
        chk("rst_grant", grant, 0);
        chk("rst_mem_valid", mbus.mem_valid, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Read port 0 from preloaded address 3
        mvc = mv_count;
        valid0 = 1'b1; wr_rd0 = 1'b0; addr0 = 4'd3;
        @(negedge clk);
        chk("t1_issue_valid", mbus.mem_valid, 1);
        chk("t1_issue_addr", mbus.mem_addr, 3);
        chk("t1_issue_wr", mbus.mem_wr_rd, 0);
        chk("t1_grant", grant, 0);
        chk("t1_busy", busy, 1);
        @(negedge clk);
        chk("t1_wait_valid", mbus.mem_valid, 0);
        @(negedge clk);
        chk("t1_ready0", ready0, 1);
        chk("t1_rdata0", rdata0, 16'hBEEF);
        chk("t1_err", err, 0);
        chk("t1_ready1", ready1, 0);
        valid0 = 1'b0;
        @(negedge clk);
        chk("t1_ready0_drop", ready0, 0);
        chk("t1_busy_drop", busy, 0);
        chk("t1_strobes", mv_count - mvc, 1);

        // Port 1 write then read of address 5
        valid1 = 1'b1; wr_rd1 = 1'b1; addr1 = 4'd5; wdata1 = 16'h1234;
        wait_rdy(1, 20, n);
        chk("t2_wr_latency", n, 3);
        chk("t2_wr_err", err, 0);
        chk("t2_wr_rdata1", rdata1, 0);
        chk("t2_wr_grant", grant, 1);
        valid1 = 1'b0;
        @(negedge clk);
        chk("t2_mem5", mem[5], 16'h1234);
        valid1 = 1'b1; wr_rd1 = 1'b0;
        wait_rdy(1, 20, n);
        chk("t2_rd_latency", n, 3);
        chk("t2_rd_rdata1", rdata1, 16'h1234);
        chk("t2_rdata0_hold", rdata0, 16'hBEEF);
        chk("t2_ready0", ready0, 0);
        valid1 = 1'b0;
        @(negedge clk);

        // Acknowledge outside WAIT
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        chk("t3_busy", busy, 0);
        chk("t3_ready", {ready1, ready0}, 0);
        @(negedge clk);
        chk("t3_ready_after", {ready1, ready0}, 0);
        chk("t3_busy_after", busy, 0);

        // Timeout on port 0 read
        mem_en = 1'b0;
        valid0 = 1'b1; wr_rd0 = 1'b0; addr0 = 4'd5;
        wait_rdy(0, 30, n);
        chk("t4_to_latency", n, 2 + TO);
        chk("t4_err", err, 1);
        chk("t4_rdata0_hold", rdata0, 16'hBEEF);
        chk("t4_ready1", ready1, 0);
        valid0 = 1'b0;
        @(negedge clk);
        chk("t4_err_drop", err, 0);
        chk("t4_ready0_drop", ready0, 0);
        mem_en = 1'b1;

        // Inputs altered and valid dropped after grant
        valid0 = 1'b1; wr_rd0 = 1'b1; addr0 = 4'd7; wdata0 = 16'hA5A5;
        @(negedge clk);
        addr0 = 4'd9; wdata0 = 16'hFFFF;
        @(negedge clk);
        valid0 = 1'b0;
        wait_rdy(0, 20, n);
        chk("t5_latency", n, 1);
        chk("t5_mem7", mem[7], 16'hA5A5);
        chk("t5_mem9", mem[9], 0);
        chk("t5_last_wa", last_wa, 7);
        chk("t5_last_wd", last_wd, 16'hA5A5);
        @(negedge clk);

        // Reset in WAIT, with port 0 served last
        mem_en = 1'b0;
        valid0 = 1'b1; wr_rd0 = 1'b0; addr0 = 4'd3;
        repeat (3) @(negedge clk);
        chk("t6_pre_busy", busy, 1);
        rst = 1'b1; valid0 = 1'b0;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_mem_valid", mbus.mem_valid, 0);
        chk("t6_grant", grant, 0);
        chk("t6_rdata0", rdata0, 0);
        chk("t6_rdata1", rdata1, 0);
        chk("t6_err", err, 0);
        chk("t6_ready", {ready1, ready0}, 0);
        rst = 1'b0; mem_en = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (ready0 || ready1) pulses++;
        end
        chk("t6_no_pulse", pulses, 0);

        // Continuous tie: grants alternate starting with port 0
        valid0 = 1'b1; wr_rd0 = 1'b0; addr0 = 4'd3;
        valid1 = 1'b1; wr_rd1 = 1'b0; addr1 = 4'd3;
        overlap = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (ready0 && ready1) overlap++;
            end while (!(ready0 || ready1) && n < 20);
            chk("t7_port", {31'd0, ready1}, k % 2);
            chk("t7_grant", grant, k % 2);
            chk("t7_gap", n, (k == 0) ? 3 : 4);
            chk("t7_rdata", (k % 2 == 1) ? rdata1 : rdata0, 16'hBEEF);
        end
        chk("t7_overlap", overlap, 0);
        valid0 = 1'b0; valid1 = 1'b0;
        repeat (4) @(negedge clk);
        chk("t7_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_2port.md
MEM_ARBITER_2PORT -- requirements
Module: mem_arbiter_2port

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  WIDTH  16  data width, equal to the memory word width
  ADDR_WIDTH  4  address width, equal to the memory address width
  TIMEOUT  8  maximum WAIT cycles before a transaction is aborted
REQ-002 The block SHALL use one clock and a synchronous active-high reset, with ports as follows (name  direction  width  meaning):
  clk_i  in  1  clock; all state changes on the rising edge
  rst_i  in  1  synchronous, active-high reset
  valid0_i / valid1_i  in  1  requester N request; held until readyN_o
  wr_rd0_i / wr_rd1_i  in  1  1 = write, 0 = read
  addr0_i / addr1_i  in  ADDR_WIDTH  requester N address
  wdata0_i / wdata1_i  in  WIDTH  requester N write data
  ready0_o / ready1_o  out  1  one-cycle completion pulse to requester N
  rdata0_o / rdata1_o  out  WIDTH  read data; valid while readyN_o=1
  err_o  out  1  timeout flag; qualified by ready0_o or ready1_o
  mem_valid_o  out  1  request strobe to the memory
  mem_wr_rd_o  out  1  write/read select to the memory
  mem_addr_o  out  ADDR_WIDTH  address to the memory
  mem_wdata_o  out  WIDTH  write data to the memory
  mem_rdata_i  in  WIDTH  read data from the memory
  mem_ready_i  in  1  memory acknowledge
  busy_o  out  1  high whenever the state is not IDLE
  grant_o  out  1  index of the requester currently or last served
REQ-003 All outputs SHALL be registered.

Function
REQ-004 The FSM SHALL have four states: IDLE, ISSUE, WAIT, DONE.
REQ-005 IDLE: if any validN_i=1, the block SHALL select a winner, latch its wr_rd/addr/wdata into the mem_* output registers, set grant_o, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-006 Arbitration SHALL be round-robin:
  - if only one requester is valid, that requester wins
  - if both are valid, the requester not served last wins
  - after reset, requester 0 wins the first tie
REQ-007 ISSUE: mem_valid_o SHALL be 1 for exactly this one cycle; next state is WAIT.
REQ-008 WAIT: mem_valid_o SHALL be 0, and a cycle counter SHALL increment each WAIT cycle.
  - mem_ready_i=1: on a read, capture mem_rdata_i into rdataN_o of the granted port; go to DONE with err_o=0
  - counter reaches TIMEOUT with no mem_ready_i: go to DONE with err_o=1; rdataN_o holds its previous value
REQ-009 DONE: readyN_o of the granted port SHALL be 1 for exactly one cycle, and err_o SHALL be valid in the same cycle.
  - record the granted port as last-served, clear the counter, return to IDLE
  - the non-granted readyM_o SHALL remain 0
REQ-010 Minimum latency SHALL be 3 cycles: a request sampled in IDLE at edge n produces readyN_o high in the cycle after edge n+2.
REQ-011 At most one memory transaction SHALL be outstanding; requests arriving while busy_o=1 SHALL wait and are never dropped.
REQ-012 The block SHALL latch address and data at grant, so a requester changing its inputs or dropping validN_i mid-transaction SHALL NOT alter the memory access; the readyN_o pulse SHALL still be issued.
REQ-013 A stray mem_ready_i outside WAIT SHALL be ignored.
REQ-014 rdataN_o SHALL hold its value until the next read completion for that port; writes SHALL NOT change rdataN_o.
REQ-015 The DONE-to-IDLE cycle SHALL always occur, so a requester that holds validN_i for one cycle after its ready pulse is re-arbitrated fairly rather than re-granted back-to-back.

Reset
REQ-016 Reset SHALL take effect at the next rising clk_i edge while rst_i=1, from any state, including mid-transaction.
REQ-017 Reset SHALL set: state=IDLE; all outputs=0; counter=0; last-served=1, so that requester 0 wins the first tie.
REQ-018 A transaction aborted by reset SHALL produce no readyN_o pulse.

Verification
REQ-019 Read, port 0: memory preloaded mem[3]=16'hBEEF; valid0_i=1, wr_rd0_i=0, addr0_i=3 -> mem_valid_o pulses once with mem_addr_o=3; ready0_o=1 three cycles later with rdata0_o=16'hBEEF, err_o=0.
REQ-020 Write then read, port 1: write addr 5 data 16'h1234, then read addr 5 -> two ready1_o pulses; second returns rdata1_o=16'h1234; rdata0_o unchanged.
REQ-021 Simultaneous requests: both valid continuously from reset -> grants alternate 0,1,0,1 over four transactions; no ready0_o/ready1_o overlap.
REQ-022 Timeout: tie mem_ready_i=0 -> ready0_o pulses with err_o=1 exactly after TIMEOUT=8 WAIT cycles; rdata0_o unchanged.
REQ-023 Reset mid-transaction: assert rst_i during WAIT -> next cycle busy_o=0 and all outputs 0; no ready pulse; next tie grants port 0.
REQ-024 Input change after grant: alter addr0_i and wdata0_i during ISSUE/WAIT -> memory is written at the originally latched address and data.
